grant_encoder: RTL and testbench
================================

# grant_encoder

Parametrised, registered request encoder: collects up to N one-hot or multi-hot request lines into a pending set and emits one binary index per accepted transfer over a valid/ready handshake. Successive requests are serialised, never dropped. Sits between the datapath control signals (register-out / bus-source strobes) and the bus multiplexer select. It replaces the fixed 32-to-5 combinational encoder where several sources can assert in the same cycle.

## Interface
- N, default 32: number of request lines, 2..64.
- W, derived, $clog2(N): index width, not overridable.
- MODE, default 0: 0 = fixed priority (lowest index first); 1 = round-robin.

- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- req  in  N  request strobes; bit i requests index i. Any number of bits may be high.
- flush  in  1  synchronous clear of all pending and presented work.
- out_ready  in  1  consumer accepts the presented index this cycle.
- out_valid  out  1  out_idx holds a valid index.
- out_idx  out  W  binary index of the presented request (bit i -> value i).
- pending  out  N  requests captured but not yet presented.
- dup  out  1  one-cycle pulse: a request merged into an already-outstanding one.
- empty  out  1  !out_valid && pending == 0 (combinational from registers).

## Operation
- State: pending register P[N-1:0]; output register {out_valid, out_idx}; round-robin pointer ptr[W-1:0] (MODE 1 only).
- Per cycle: load = !out_valid || out_ready; C = P | req.
- If load and C != 0: sel = pick(C); out_idx <= sel; out_valid <= 1; P <= C & ~(1 << sel); ptr <= sel.
- If load and C == 0: out_valid <= 0; out_idx holds its value; P <= 0.
- If !load: out_valid and out_idx hold (stable while stalled); P <= C.
- pick, MODE 0: lowest set index in C.
- pick, MODE 1: first set index strictly after ptr, wrapping N-1 -> 0; if only ptr itself is set, pick ptr.
- Duplicate: dup <= 1 next cycle if any req[i] with P[i] = 1, or req[i] with out_valid && out_idx == i && !out_ready. The request is merged, producing no extra grant. A req[i] arriving in the same cycle its index is consumed is a new request and is captured.
- flush: highest priority. P <= 0, out_valid <= 0, dup <= 0; req in the same cycle is discarded; ptr unchanged.
- Reset (clr_n low, asynchronous): P = 0, out_valid = 0, out_idx = 0, dup = 0, ptr = N-1, so the first MODE 1 pick starts at index 0. Reset asserted mid-transfer abandons all work. There is no output until a new req arrives after release.
- Non-power-of-two N: indices >= N never produced; ptr wraps at N-1.

## Timing
- Latency: req at edge k -> out_valid, out_idx after edge k (1 cycle) when the output register is free.
- Throughput: one index per cycle while out_ready = 1 and C != 0.
- Stall: out_idx and out_valid remain constant while out_valid && !out_ready; new requests accumulate in P.
- M simultaneous requests with out_ready held high: indices appear on M consecutive cycles in pick order, then out_valid falls the next cycle if there are no new requests.
- dup registered: asserted the cycle after the offending req, for exactly one cycle per occurrence cycle.
- No combinational path from req or out_ready to any output except empty (which is derived from registers only).

## Test plan
- Reset/single: clr_n low mid-stream, then release; req = 32'h0000_0100 for one cycle -> next cycle out_valid = 1, out_idx = 8; out_ready = 1 -> out_valid = 0, empty = 1.
- Fixed-priority burst (MODE 0): req = 32'h8000_0005 for one cycle, out_ready = 1 -> out_idx 0, 2, 31 on three consecutive cycles, then out_valid = 0.
- Round-robin (MODE 1): after granting 5, hold req bits 2, 5, 9 continuously with out_ready = 1 -> grant sequence 9, 2, 5, 9, 2 ...
- Stall/duplicate: out_idx = 3 presented with out_ready = 0; pulse req[3] and req[7] -> out_idx stays 3, dup pulses once, pending = 1 << 7. Release out_ready -> 3, then 7, with no second 3.
- Flush collision: P = 32'h0000_00F0, out_valid = 1; assert flush with req[1] high -> next cycle out_valid = 0, pending = 0, empty = 1, and 1 is never granted.
- Parametrisation: N = 5, MODE 1 -> W = 3; req = 5'b10001 held -> grants 0, 4, 0, 4; out_idx never exceeds 4.

Source files
------------

// File: rtl/grant_encoder.sv
// Registered request encoder: gathers request strobes into a pending set
// and presents one binary index per valid/ready transfer.
module grant_encoder #(
    parameter int N    = 32,
    parameter int MODE = 0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] req,
    input  logic         flush,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending,
    output logic         dup,
    output logic         empty
);

    logic [W-1:0] ptr;
    logic         hold;
    logic [N-1:0] busy;
    logic [N-1:0] cand;
    logic [N-1:0] grant;
    logic [W-1:0] sel;
    logic         dup_d;
    logic         found;
    logic [W:0]   sum;
    logic [W-1:0] j;

    // Merge requests, detect duplicates and choose the next index to present.
    always_comb begin
        hold  = out_valid && !out_ready;
        busy  = '0;
        if (hold) begin
            busy[out_idx] = 1'b1;
        end
        // A request for the stalled, presented index is already covered.
        cand  = pending | (req & ~busy);
        dup_d = |(req & (pending | busy));
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        j     = '0;
        if (MODE == 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                j = W'(i);
                if (cand[j]) begin
                    sel = j;
                end
            end
        end else begin
            // Scan ptr+1 .. ptr+N so ptr itself is the last candidate.
            for (int off = 1; off <= N; off++) begin
                sum = {1'b0, ptr} + (W+1)'(off);
                if (sum >= (W+1)'(N)) begin
                    sum = sum - (W+1)'(N);
                end
                j = sum[W-1:0];
                if (!found && cand[j]) begin
                    sel   = j;
                    found = 1'b1;
                end
            end
        end
        grant      = '0;
        grant[sel] = 1'b1;
    end

    // Pending set, output register, duplicate pulse and round-robin pointer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            dup       <= 1'b0;
            ptr       <= W'(N - 1);
        end else if (flush) begin
            pending   <= '0;
            out_valid <= 1'b0;
            dup       <= 1'b0;
        end else begin
            dup <= dup_d;
            if (hold) begin
                pending <= cand;
            end else if (|cand) begin
                out_idx   <= sel;
                out_valid <= 1'b1;
                pending   <= cand & ~grant;
                ptr       <= sel;
            end else begin
                out_valid <= 1'b0;
                pending   <= '0;
            end
        end
    end

    // Idle indication depends on registered state only.
    always_comb begin
        empty = !out_valid && (pending == '0);
    end

endmodule

// File: tb/tb_grant_encoder.sv
// Bench for grant_encoder: directed vector table, directed multi-cycle
// sequences and randomized traffic against a set-based reference model.
module tb_grant_encoder;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;

    logic [31:0] r0 = '0;
    logic        rd0 = 1'b0, fl0 = 1'b0;
    logic        ov0, du0, em0;
    logic [4:0]  oi0;
    logic [31:0] pe0;

    logic [31:0] r1 = '0;
    logic        rd1 = 1'b0, fl1 = 1'b0;
    logic        ov1, du1, em1;
    logic [4:0]  oi1;
    logic [31:0] pe1;

    logic [4:0]  r2 = '0;
    logic        rd2 = 1'b0, fl2 = 1'b0;
    logic        ov2, du2, em2;
    logic [2:0]  oi2;
    logic [4:0]  pe2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    grant_encoder #(.N(32), .MODE(0)) u0 (
        .clk(clk), .clr_n(clr_n), .req(r0), .flush(fl0),
        .out_ready(rd0), .out_valid(ov0), .out_idx(oi0),
        .pending(pe0), .dup(du0), .empty(em0)
    );

    grant_encoder #(.N(32), .MODE(1)) u1 (
        .clk(clk), .clr_n(clr_n), .req(r1), .flush(fl1),
        .out_ready(rd1), .out_valid(ov1), .out_idx(oi1),
        .pending(pe1), .dup(du1), .empty(em1)
    );

    grant_encoder #(.N(5), .MODE(1)) u2 (
        .clk(clk), .clr_n(clr_n), .req(r2), .flush(fl2),
        .out_ready(rd2), .out_valid(ov2), .out_idx(oi2),
        .pending(pe2), .dup(du2), .empty(em2)
    );

    // Reference model state, one slot per instance.
    bit [63:0] mp[3];
    bit        mv[3];
    int        mi[3];
    int        mptr[3];
    bit        md[3];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset(int k, int n);
        mp[k]   = '0;
        mv[k]   = 1'b0;
        mi[k]   = 0;
        md[k]   = 1'b0;
        mptr[k] = n - 1;
    endtask

    task automatic model_step(int k, int n, int mode, logic [63:0] r,
                              bit fl, bit rdy);
        bit stall;
        bit nd;
        int pick;
        if (fl) begin
            mp[k] = '0;
            mv[k] = 1'b0;
            md[k] = 1'b0;
            return;
        end
        stall = mv[k] && !rdy;
        nd = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (r[i]) begin
                if (mp[k][i] || (stall && mi[k] == i)) nd = 1'b1;
                else mp[k][i] = 1'b1;
            end
        end
        md[k] = nd;
        if (stall) return;
        if (mp[k] == 0) begin
            mv[k] = 1'b0;
            return;
        end
        pick = -1;
        if (mode == 0) begin
            for (int i = n - 1; i >= 0; i--)
                if (mp[k][i]) pick = i;
        end else begin
            for (int s = n; s >= 1; s--)
                if (mp[k][(mptr[k] + s) % n]) pick = (mptr[k] + s) % n;
        end
        mv[k] = 1'b1;
        mi[k] = pick;
        mp[k][pick] = 1'b0;
        mptr[k] = pick;
    endtask

    task automatic cmp_all();
        chk("u0.valid", 64'(ov0), 64'(mv[0]));
        chk("u0.idx", 64'(oi0), 64'(mi[0]));
        chk("u0.pending", 64'(pe0), mp[0]);
        chk("u0.dup", 64'(du0), 64'(md[0]));
        chk("u0.empty", 64'(em0), 64'(!mv[0] && mp[0] == 0));
        chk("u1.valid", 64'(ov1), 64'(mv[1]));
        chk("u1.idx", 64'(oi1), 64'(mi[1]));
        chk("u1.pending", 64'(pe1), mp[1]);
        chk("u1.dup", 64'(du1), 64'(md[1]));
        chk("u1.empty", 64'(em1), 64'(!mv[1] && mp[1] == 0));
        chk("u2.valid", 64'(ov2), 64'(mv[2]));
        chk("u2.idx", 64'(oi2), 64'(mi[2]));
        chk("u2.pending", 64'(pe2), mp[2]);
        chk("u2.dup", 64'(du2), 64'(md[2]));
        chk("u2.empty", 64'(em2), 64'(!mv[2] && mp[2] == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 32, 0, {32'b0, r0}, fl0, rd0);
        model_step(1, 32, 1, {32'b0, r1}, fl1, rd1);
        model_step(2, 5, 1, {59'b0, r2}, fl2, rd2);
        #1;
        cmp_all();
    endtask

    // Asynchronous reset in the middle of a cycle.
    task automatic do_reset();
        #3;
        clr_n = 1'b0;
        model_reset(0, 32);
        model_reset(1, 32);
        model_reset(2, 5);
        #1;
        cmp_all();
        r0 = '0; r1 = '0; r2 = '0;
        fl0 = 0; fl1 = 0; fl2 = 0;
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] req;
        bit          rdy;
        bit          fl;
        bit          ev;
        int          ei;
        logic [31:0] ep;
        bit          ed;
    } vec_t;

    vec_t vt[17];
    int   rr[5];
    int   n5[4];

    initial begin
        vt[0]  = '{32'h0000_0100, 0, 0, 1, 8,  32'h0,         0};
        vt[1]  = '{32'h0,         1, 0, 0, 8,  32'h0,         0};
        vt[2]  = '{32'h8000_0005, 1, 0, 1, 0,  32'h8000_0004, 0};
        vt[3]  = '{32'h0,         1, 0, 1, 2,  32'h8000_0000, 0};
        vt[4]  = '{32'h0,         1, 0, 1, 31, 32'h0,         0};
        vt[5]  = '{32'h0,         1, 0, 0, 31, 32'h0,         0};
        vt[6]  = '{32'h0000_0008, 0, 0, 1, 3,  32'h0,         0};
        vt[7]  = '{32'h0000_0088, 0, 0, 1, 3,  32'h0000_0080, 1};
        vt[8]  = '{32'h0,         0, 0, 1, 3,  32'h0000_0080, 0};
        vt[9]  = '{32'h0,         1, 0, 1, 7,  32'h0,         0};
        vt[10] = '{32'h0,         1, 0, 0, 7,  32'h0,         0};
        vt[11] = '{32'h0000_00F8, 0, 0, 1, 3,  32'h0000_00F0, 0};
        vt[12] = '{32'h0000_0002, 0, 1, 0, 3,  32'h0,         0};
        vt[13] = '{32'h0,         1, 0, 0, 3,  32'h0,         0};
        vt[14] = '{32'h0000_0010, 1, 0, 1, 4,  32'h0,         0};
        vt[15] = '{32'h0000_0010, 1, 0, 1, 4,  32'h0,         0};
        vt[16] = '{32'h0,         1, 0, 0, 4,  32'h0,         0};
        rr = '{9, 2, 5, 9, 2};
        n5 = '{0, 4, 0, 4};

        model_reset(0, 32);
        model_reset(1, 32);
        model_reset(2, 5);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        r0 = 32'hFFFF_0000;
        rd0 = 1'b0;
        tick();
        tick();
        do_reset();

        // Fixed-priority directed vectors.
        for (int i = 0; i < 17; i++) begin
            r0 = vt[i].req;
            rd0 = vt[i].rdy;
            fl0 = vt[i].fl;
            tick();
            chk($sformatf("vec%0d.valid", i), 64'(ov0), 64'(vt[i].ev));
            chk($sformatf("vec%0d.idx", i), 64'(oi0), 64'(vt[i].ei));
            chk($sformatf("vec%0d.pending", i), 64'(pe0), 64'(vt[i].ep));
            chk($sformatf("vec%0d.dup", i), 64'(du0), 64'(vt[i].ed));
            chk($sformatf("vec%0d.empty", i), 64'(em0),
                64'(!vt[i].ev && vt[i].ep == 0));
        end
        r0 = '0; fl0 = 0;

        // Round-robin on 32 lines.
        do_reset();
        rd1 = 1'b1;
        r1 = 32'h0000_0020;
        tick();
        chk("rr.first", 64'(oi1), 64'd5);
        r1 = 32'h0000_0224;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr.seq%0d", i), 64'(oi1), 64'(rr[i]));
            chk($sformatf("rr.valid%0d", i), 64'(ov1), 64'd1);
        end
        r1 = '0;
        repeat (4) tick();

        // Five-line round-robin with a non-power-of-two wrap.
        do_reset();
        rd2 = 1'b1;
        r2 = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("n5.seq%0d", i), 64'(oi2), 64'(n5[i]));
        end
        r2 = '0;
        repeat (3) tick();

        // Randomized traffic on all three instances.
        for (int c = 0; c < 1500; c++) begin
            r0 = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            r1 = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
            r2 = 5'($urandom & $urandom);
            rd0 = ($urandom_range(0, 3) != 0);
            rd1 = ($urandom_range(0, 3) != 0);
            rd2 = ($urandom_range(0, 2) != 0);
            fl0 = ($urandom_range(0, 40) == 0);
            fl1 = ($urandom_range(0, 40) == 0);
            fl2 = ($urandom_range(0, 40) == 0);
            if (c == 700) begin
                do_reset();
            end else begin
                tick();
                if (ov2) chk("n5.range", 64'(oi2 <= 3'd4), 64'd1);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
